// File: rtl/jt10_adpcm_rom_arb.sv
// -----------------------------------------------------------------------------
// jt10_adpcm_rom_arb
//
// Shares one external ADPCM sample ROM port between the ADPCM-B driver and NCH
// ADPCM-A channels. Each requester holds a level request plus an address and
// gets back a one-clock ack together with a registered data byte. ADPCM-A
// channels are served round-robin; B is alternated with A so neither starves.
//
// Optional build macro: JT10_ADPCM_ROM_CACHE_EN
//   When defined, each requester keeps a one-entry tag/valid cache. A grant
//   whose address matches a valid tag completes without touching the ROM.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   a_req     per-channel ADPCM-A request (level)
//   a_addr    flattened A addresses, channel k at [k*AW +: AW]
//   a_ack     one-clock completion pulse per A channel
//   a_data    per-channel data registers, flattened like a_addr (8 bits each)
//   b_req     ADPCM-B request (level)
//   b_addr    ADPCM-B address
//   b_ack     ADPCM-B one-clock completion pulse
//   b_data    ADPCM-B data register
//   rom_addr  registered ROM address
//   rom_cs    registered ROM access strobe
//   rom_ok    ROM data-valid
//   rom_data  ROM data
//   err       sticky ROM timeout flag
// -----------------------------------------------------------------------------
module jt10_adpcm_rom_arb #(
    parameter int NCH  = 6,
    parameter int AW   = 24,
    parameter int TOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    a_req,
    input  logic [NCH*AW-1:0] a_addr,
    output logic [NCH-1:0]    a_ack,
    output logic [NCH*8-1:0]  a_data,
    input  logic              b_req,
    input  logic [AW-1:0]     b_addr,
    output logic              b_ack,
    output logic [7:0]        b_data,
    output logic [AW-1:0]     rom_addr,
    output logic              rom_cs,
    input  logic              rom_ok,
    input  logic [7:0]        rom_data,
    output logic              err
);

    // Requesters are numbered 0..NCH-1 for A channels and NCH for B.
    localparam int NREQ = NCH + 1;
    localparam int IDW  = $clog2(NREQ);
    localparam logic [IDW-1:0] B_ID = IDW'(NCH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]     state_reg;
    logic [IDW-1:0] rr_ptr_reg;
    logic           last_b_reg;
    logic [IDW-1:0] sel_id_reg;
    logic [AW-1:0]  sel_addr_reg;
    logic [7:0]     tout_cnt_reg;
    logic [AW-1:0]  rom_addr_reg;
    logic           rom_cs_reg;
    logic           err_reg;
    logic [NCH-1:0] a_ack_reg;
    logic           b_ack_reg;
    logic [7:0]     data_reg [NREQ];

    // Unpack the flattened A buses.
    logic [AW-1:0]  a_addr_arr [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign a_addr_arr[gi]      = a_addr[gi*AW +: AW];
            assign a_data[gi*8 +: 8]   = data_reg[gi];
        end
    endgenerate

    assign b_data   = data_reg[NCH];
    assign a_ack    = a_ack_reg;
    assign b_ack    = b_ack_reg;
    assign rom_addr = rom_addr_reg;
    assign rom_cs   = rom_cs_reg;
    assign err      = err_reg;

    // Round-robin scan: first pending A channel at or above rr_ptr, wrapping.
    logic           a_found;
    logic [IDW-1:0] a_pick;
    int             scan_idx;

    always_comb begin
        a_found  = 1'b0;
        a_pick   = '0;
        scan_idx = 0;
        for (int i = 0; i < NCH; i++) begin
            scan_idx = int'(rr_ptr_reg) + i;
            if (scan_idx >= NCH) begin
                scan_idx = scan_idx - NCH;
            end
            if (!a_found && a_req[scan_idx]) begin
                a_found = 1'b1;
                a_pick  = IDW'(scan_idx);
            end
        end
    end

    // B wins unless it was served last and some A channel is waiting.
    logic           grant;
    logic [IDW-1:0] grant_id;
    logic [AW-1:0]  grant_addr;

    always_comb begin
        grant      = 1'b0;
        grant_id   = '0;
        grant_addr = '0;
        if (b_req && (!last_b_reg || !a_found)) begin
            grant      = 1'b1;
            grant_id   = B_ID;
            grant_addr = b_addr;
        end else if (a_found) begin
            grant      = 1'b1;
            grant_id   = a_pick;
            grant_addr = a_addr_arr[a_pick];
        end
    end

    logic [IDW-1:0]  rr_next;
    logic [NREQ-1:0] sel_onehot;
    logic [7:0]      tout_next;
    logic            tout_hit;
    logic            fill_ok;
    logic            fill_tout;
    logic            cache_hit;

    assign rr_next    = (a_pick == IDW'(NCH - 1)) ? '0 : a_pick + 1'b1;
    assign sel_onehot = NREQ'(1) << sel_id_reg;
    assign tout_next  = tout_cnt_reg + 8'd1;
    assign tout_hit   = (tout_next == 8'(TOUT));
    // rom_ok is checked first, so a response arriving on the timeout cycle
    // still counts as a normal completion.
    assign fill_ok    = (state_reg == ST_WAIT) && rom_ok;
    assign fill_tout  = (state_reg == ST_WAIT) && !rom_ok && tout_hit;

`ifdef JT10_ADPCM_ROM_CACHE_EN
    logic [AW-1:0]   tag_reg [NREQ];
    logic [NREQ-1:0] valid_reg;

    // The hit test runs in the ISSUE slot on the latched address, which keeps
    // the tag compare off the grant path; a hit acks at cycle 2 with no rom_cs.
    assign cache_hit = valid_reg[sel_id_reg] && (tag_reg[sel_id_reg] == sel_addr_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                tag_reg[i] <= '0;
            end
            valid_reg <= '0;
        end else if (fill_ok) begin
            tag_reg[sel_id_reg]   <= sel_addr_reg;
            valid_reg[sel_id_reg] <= 1'b1;
        end else if (fill_tout) begin
            // A forced zero is not real ROM content; do not let it hit later.
            valid_reg[sel_id_reg] <= 1'b0;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            last_b_reg   <= 1'b0;
            sel_id_reg   <= '0;
            sel_addr_reg <= '0;
            tout_cnt_reg <= '0;
            rom_addr_reg <= '0;
            rom_cs_reg   <= 1'b0;
            err_reg      <= 1'b0;
            a_ack_reg    <= '0;
            b_ack_reg    <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            // Acks are single-cycle pulses; only a completion raises one.
            a_ack_reg <= '0;
            b_ack_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant) begin
                        sel_id_reg   <= grant_id;
                        sel_addr_reg <= grant_addr;
                        if (grant_id == B_ID) begin
                            last_b_reg <= 1'b1;
                        end else begin
                            last_b_reg <= 1'b0;
                            rr_ptr_reg <= rr_next;
                        end
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cache_hit) begin
                        a_ack_reg <= sel_onehot[NCH-1:0];
                        b_ack_reg <= sel_onehot[NCH];
                        state_reg <= ST_DONE;
                    end else begin
                        rom_addr_reg <= sel_addr_reg;
                        rom_cs_reg   <= 1'b1;
                        tout_cnt_reg <= '0;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (fill_ok) begin
                        data_reg[sel_id_reg] <= rom_data;
                        a_ack_reg  <= sel_onehot[NCH-1:0];
                        b_ack_reg  <= sel_onehot[NCH];
                        rom_cs_reg <= 1'b0;
                        state_reg  <= ST_DONE;
                    end else if (fill_tout) begin
                        data_reg[sel_id_reg] <= 8'h00;
                        a_ack_reg  <= sel_onehot[NCH-1:0];
                        b_ack_reg  <= sel_onehot[NCH];
                        rom_cs_reg <= 1'b0;
                        err_reg    <= 1'b1;
                        state_reg  <= ST_DONE;
                    end else begin
                        tout_cnt_reg <= tout_next;
                    end
                end
                default: begin
                    // DONE: one quiet cycle so the served request is seen low.
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// -----------------------------------------------------------------------------
// Testbench for jt10_adpcm_rom_arb. A small ROM model answers rom_cs one clock
// later (when enabled). Each scenario pushes the expected (requester, data)
// sequence to a scoreboard queue and pops/compares on every ack.
// -----------------------------------------------------------------------------
module tb_jt10_adpcm_rom_arb;

    localparam int NCH  = 6;
    localparam int AW   = 24;
    localparam int TOUT = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    a_req;
    logic [NCH*AW-1:0] a_addr;
    logic [NCH-1:0]    a_ack;
    logic [NCH*8-1:0]  a_data;
    logic              b_req;
    logic [AW-1:0]     b_addr;
    logic              b_ack;
    logic [7:0]        b_data;
    logic [AW-1:0]     rom_addr;
    logic              rom_cs;
    logic              rom_ok;
    logic [7:0]        rom_data;
    logic              err;

    logic rom_en;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    jt10_adpcm_rom_arb #(.NCH(NCH), .AW(AW), .TOUT(TOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_addr   (a_addr),
        .a_ack    (a_ack),
        .a_data   (a_data),
        .b_req    (b_req),
        .b_addr   (b_addr),
        .b_ack    (b_ack),
        .b_data   (b_data),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .rom_data (rom_data),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
        if (a == 24'h012345) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    // ROM model: one-cycle pulse of rom_ok one clock after it sees rom_cs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_ok   <= 1'b0;
            rom_data <= 8'h00;
        end else begin
            rom_ok   <= rom_en && rom_cs && !rom_ok;
            rom_data <= rom_fn(rom_addr);
        end
    end

    function automatic logic [AW-1:0] ch_addr(input int k);
        return AW'(24'h000200 + k * 24'h000111);
    endfunction

    function automatic logic [7:0] data_of(input int ch);
        if (ch == NCH) return b_data;
        if (ch >= 0 && ch < NCH) return a_data[ch*8 +: 8];
        return 8'hxx;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        if (exp_q.size() == 0) begin
            e.id   = -2;
            e.data = 8'hxx;
        end else begin
            e = exp_q.pop_front();
        end
        return e;
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        a_req = '0;
        b_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for any ack; cycle 1 is the first negedge after the call.
    task automatic wait_ack(input int limit, output int id, output int cyc,
                            output int cs_cnt, output logic [AW-1:0] cs_addr);
        id      = -1;
        cyc     = 0;
        cs_cnt  = 0;
        cs_addr = '0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (rom_cs) begin
                if (cs_cnt == 0) cs_addr = rom_addr;
                cs_cnt++;
            end
            if (b_ack) begin
                id = NCH;
            end else begin
                for (int k = NCH - 1; k >= 0; k--) begin
                    if (a_ack[k]) id = k;
                end
            end
            if (id >= 0) begin
                $display("txn ack id=%0d data=%02h cyc=%0d rom_cs_cycles=%0d", id, data_of(id), cyc, cs_cnt);
                return;
            end
        end
        $display("txn no ack within %0d cycles", limit);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        a_req  = '0;
        b_req  = 1'b0;
        a_addr = '0;
        b_addr = '0;
        rom_en = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({rom_cs, rom_addr} !== {1'b0, {AW{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_rom got cs=%b addr=%06h want cs=0 addr=000000", rom_cs, rom_addr);
        end
        n_cmp++;
        if ({a_ack, b_ack, err} !== '0) begin
            n_err++;
            $display("FAIL reset_flags got a_ack=%b b_ack=%b err=%b want all 0", a_ack, b_ack, err);
        end
        n_cmp++;
        if ({a_data, b_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data got a_data=%h b_data=%02h want 0", a_data, b_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_b();
        int id, cyc, csn;
        logic [AW-1:0] csa;
        exp_t e;
        do_reset();
        rom_en = 1'b1;
        b_addr = 24'h012345;
        b_req  = 1'b1;
        exp_q.push_back('{NCH, 8'hA5});
        wait_ack(20, id, cyc, csn, csa);
        b_req = 1'b0;
        e = pop_exp();
        n_cmp++;
        if (id !== e.id) begin
            n_err++;
            $display("FAIL single_b_id got %0d want %0d", id, e.id);
        end
        n_cmp++;
        if (cyc !== 4) begin
            n_err++;
            $display("FAIL single_b_latency got %0d want 4", cyc);
        end
        n_cmp++;
        if (csa !== 24'h012345) begin
            n_err++;
            $display("FAIL single_b_rom_addr got %06h want 012345", csa);
        end
        n_cmp++;
        if (b_data !== e.data) begin
            n_err++;
            $display("FAIL single_b_data got %02h want %02h", b_data, e.data);
        end
        n_cmp++;
        if (a_ack !== '0) begin
            n_err++;
            $display("FAIL single_b_a_ack got %b want 0", a_ack);
        end
        @(negedge clk);
        n_cmp++;
        if (b_ack !== 1'b0) begin
            n_err++;
            $display("FAIL single_b_pulse got b_ack=%b one clk later want 0", b_ack);
        end
    endtask

    task automatic test_round_robin();
        int id, cyc, csn;
        logic [AW-1:0] csa;
        exp_t e;
        do_reset();
        rom_en = 1'b1;
        for (int k = 0; k < NCH; k++) a_addr[k*AW +: AW] = ch_addr(k);
        for (int g = 0; g < 7; g++) exp_q.push_back('{g % NCH, rom_fn(ch_addr(g % NCH))});
        a_req = '1;
        for (int g = 0; g < 7; g++) begin
            wait_ack(20, id, cyc, csn, csa);
            e = pop_exp();
            n_cmp++;
            if (id !== e.id) begin
                n_err++;
                $display("FAIL rr_order grant %0d got ch %0d want ch %0d", g, id, e.id);
            end
            n_cmp++;
            if (data_of(e.id) !== e.data || $countones({a_ack, b_ack}) != 1) begin
                n_err++;
                $display("FAIL rr_data grant %0d got data=%02h acks=%b%b want data=%02h one ack",
                         g, data_of(e.id), a_ack, b_ack, e.data);
            end
            n_cmp++;
            if (cyc !== 4) begin
                n_err++;
                $display("FAIL rr_spacing grant %0d got %0d want 4", g, cyc);
            end
            if (g == 6) begin
                a_req = '0;
            end else begin
                if (id >= 0 && id < NCH) a_req[id] = 1'b0;
                @(negedge clk);
                if (id >= 0 && id < NCH) a_req[id] = 1'b1;
            end
        end
    endtask

    task automatic test_alternation();
        int id, cyc, csn;
        logic [AW-1:0] csa;
        exp_t e;
        do_reset();
        rom_en = 1'b1;
        b_addr = 24'h000777;
        a_addr[2*AW +: AW] = 24'h000888;
        for (int g = 0; g < 6; g++) begin
            if (g % 2 == 0) exp_q.push_back('{NCH, rom_fn(24'h000777)});
            else            exp_q.push_back('{2, rom_fn(24'h000888)});
        end
        b_req    = 1'b1;
        a_req[2] = 1'b1;
        for (int g = 0; g < 6; g++) begin
            wait_ack(20, id, cyc, csn, csa);
            e = pop_exp();
            n_cmp++;
            if (id !== e.id) begin
                n_err++;
                $display("FAIL alt_order grant %0d got %0d want %0d", g, id, e.id);
            end
            n_cmp++;
            if (data_of(e.id) !== e.data) begin
                n_err++;
                $display("FAIL alt_data grant %0d got %02h want %02h", g, data_of(e.id), e.data);
            end
            if (g == 5) begin
                a_req = '0;
                b_req = 1'b0;
            end else begin
                if (id == NCH) b_req = 1'b0;
                else if (id == 2) a_req[2] = 1'b0;
                @(negedge clk);
                if (id == NCH) b_req = 1'b1;
                else if (id == 2) a_req[2] = 1'b1;
            end
        end
    endtask

    task automatic test_timeout();
        int id, cyc, csn;
        logic [AW-1:0] csa;
        exp_t e;
        do_reset();
        // Load a non-zero b_data first so the forced zero is visible.
        rom_en = 1'b1;
        b_addr = 24'h000ABC;
        b_req  = 1'b1;
        exp_q.push_back('{NCH, rom_fn(24'h000ABC)});
        wait_ack(20, id, cyc, csn, csa);
        b_req = 1'b0;
        e = pop_exp();
        n_cmp++;
        if (id !== e.id || b_data !== e.data || err !== 1'b0) begin
            n_err++;
            $display("FAIL tout_pre got id=%0d data=%02h err=%b want id=%0d data=%02h err=0",
                     id, b_data, err, e.id, e.data);
        end
        @(negedge clk);
        rom_en = 1'b0;
        b_req  = 1'b1;
        exp_q.push_back('{NCH, 8'h00});
        wait_ack(400, id, cyc, csn, csa);
        b_req = 1'b0;
        e = pop_exp();
        n_cmp++;
        if (id !== e.id || b_data !== e.data) begin
            n_err++;
            $display("FAIL tout_ack got id=%0d data=%02h want id=%0d data=%02h", id, b_data, e.id, e.data);
        end
        n_cmp++;
        if (cyc !== 257 || csn !== TOUT) begin
            n_err++;
            $display("FAIL tout_length got ack_cyc=%0d wait_cycles=%0d want 257 and %0d", cyc, csn, TOUT);
        end
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL tout_err got %b want 1", err);
        end
        @(negedge clk);
        rom_en = 1'b1;
        a_addr[1*AW +: AW] = 24'h000345;
        a_req[1] = 1'b1;
        exp_q.push_back('{1, rom_fn(24'h000345)});
        wait_ack(20, id, cyc, csn, csa);
        a_req[1] = 1'b0;
        e = pop_exp();
        n_cmp++;
        if (id !== e.id || data_of(e.id) !== e.data) begin
            n_err++;
            $display("FAIL tout_after got id=%0d data=%02h want id=%0d data=%02h", id, data_of(e.id), e.id, e.data);
        end
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL tout_sticky got err=%b want 1", err);
        end
    endtask

    task automatic test_reset_mid();
        int id, cyc, csn;
        logic [AW-1:0] csa;
        exp_t e;
        @(negedge clk);
        rom_en = 1'b0;
        b_addr = 24'h000DEF;
        b_req  = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rom_cs !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_setup got rom_cs=%b want 1", rom_cs);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({rom_cs, a_ack, b_ack, err} !== '0 || {a_data, b_data} !== '0) begin
            n_err++;
            $display("FAIL rstmid_clear got cs=%b acks=%b%b err=%b a_data=%h b_data=%02h want all 0",
                     rom_cs, a_ack, b_ack, err, a_data, b_data);
        end
        b_req = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        rom_en = 1'b1;
        a_addr[3*AW +: AW] = 24'h000456;
        a_req[3] = 1'b1;
        exp_q.push_back('{3, rom_fn(24'h000456)});
        wait_ack(20, id, cyc, csn, csa);
        a_req[3] = 1'b0;
        e = pop_exp();
        n_cmp++;
        if (id !== e.id || data_of(e.id) !== e.data || cyc !== 4) begin
            n_err++;
            $display("FAIL rstmid_after got id=%0d data=%02h cyc=%0d want id=%0d data=%02h cyc=4",
                     id, data_of(e.id), cyc, e.id, e.data);
        end
    endtask

    task automatic test_repeat_read();
        int id, cyc, csn;
        logic [AW-1:0] csa;
        exp_t e;
        do_reset();
        rom_en = 1'b1;
        a_addr[0 +: AW] = 24'h000100;
        a_req[0] = 1'b1;
        exp_q.push_back('{0, rom_fn(24'h000100)});
        wait_ack(20, id, cyc, csn, csa);
        a_req[0] = 1'b0;
        e = pop_exp();
        n_cmp++;
        if (id !== e.id || data_of(0) !== e.data || csn !== 2) begin
            n_err++;
            $display("FAIL rep_first got id=%0d data=%02h cs_cycles=%0d want id=0 data=%02h cs_cycles=2",
                     id, data_of(0), csn, e.data);
        end
        @(negedge clk);
        a_req[0] = 1'b1;
        exp_q.push_back('{0, rom_fn(24'h000100)});
        wait_ack(20, id, cyc, csn, csa);
        a_req[0] = 1'b0;
        e = pop_exp();
        n_cmp++;
        if (id !== e.id || data_of(0) !== e.data) begin
            n_err++;
            $display("FAIL rep_second got id=%0d data=%02h want id=0 data=%02h", id, data_of(0), e.data);
        end
`ifdef JT10_ADPCM_ROM_CACHE_EN
        n_cmp++;
        if (cyc !== 2 || csn !== 0) begin
            n_err++;
            $display("FAIL rep_hit got ack_cyc=%0d cs_cycles=%0d want 2 and 0", cyc, csn);
        end
`else
        n_cmp++;
        if (cyc !== 4 || csn !== 2) begin
            n_err++;
            $display("FAIL rep_nocache got ack_cyc=%0d cs_cycles=%0d want 4 and 2", cyc, csn);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_b();
        test_round_robin();
        test_alternation();
        test_timeout();
        test_reset_mid();
        test_repeat_read();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish by 1ms want finish");
        $fatal(1);
    end

endmodule
